axi_lite_regbank: RTL

//  Parametrised AXI4-Lite slave register bank that supersedes the fixed per-module interface.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/regbank_word.sv | 45 ++++
 rtl/axi_lite_regbank.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the parametrised register bank.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/regbank_word.sv
// One register word: byte-strobe merge, reset value, and read-only / self-clearing pulse modes.
module regbank_word #(
    parameter int            DW       = 32,
    parameter bit            IS_RO    = 1'b0,
    parameter bit            IS_PULSE = 1'b0,
    parameter logic [DW-1:0] RST_VAL  = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    output logic [DW-1:0]   q_o
);

    generate
        if (IS_RO) begin : gRo
            // Fabric owns the value; the bank only reflects zero on reg_out.
            logic unused;
            assign unused = ^{clk_i, rst_i, we_i, wdata_i, wstrb_i};
            assign q_o    = '0;
        end else begin : gReg
            logic [DW-1:0] word_q;
            logic [DW-1:0] word_d;

            // Pulse words start from zero so written bits only live for one cycle.
            always_comb begin
                word_d = IS_PULSE ? '0 : word_q;
                if (we_i) begin
                    for (int b = 0; b < DW/8; b++) begin
                        if (wstrb_i[b]) word_d[b*8 +: 8] = wdata_i[b*8 +: 8];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) word_q <= RST_VAL;
                else       word_q <= word_d;
            end

            assign q_o = word_q;
        end
    endgenerate

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: independent AW/W capture, write/read FSMs, read mux and word array.
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 11,
    parameter int NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] PULSE_MASK = '0,
    parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                    wr_pulse,
    output logic [NUM_REGS-1:0]                    rd_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int ADDR_LSB = $clog2(DW/8);
    localparam int IW       = AW - ADDR_LSB;

    wr_state_e wrState_q, wrState_d;
    rd_state_e rdState_q, rdState_d;
    logic                alive_q;
    logic [IW-1:0]       awIdx_q;
    logic [DW-1:0]       wData_q;
    logic [DW/8-1:0]     wStrb_q;
    logic [1:0]          bResp_q, rResp_q;
    logic [DW-1:0]       rData_q;
    logic [NUM_REGS-1:0] wrPulse_q, rdPulse_q;

    logic awFire, wFire, arFire, commit, wrOk, rdHit;
    logic [IW-1:0]       wrIdx, rdIdx;
    logic [DW-1:0]       cData, rdWord;
    logic [DW/8-1:0]     cStrb;
    logic [NUM_REGS-1:0] wrSel, rdSel, wrWe;
    logic [NUM_REGS*DW-1:0] regVal;

    logic unused;
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};

    // alive_q holds the readies low during reset and for the edge that releases it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            alive_q   <= 1'b0;
            wrState_q <= W_IDLE;
            rdState_q <= R_IDLE;
        end else begin
            alive_q   <= 1'b1;
            wrState_q <= wrState_d;
            rdState_q <= rdState_d;
        end
    end

    assign awFire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign wFire  = S_AXI_WVALID  && S_AXI_WREADY;
    assign arFire = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (wrState_q == W_IDLE    && awFire && wFire) ||
                    (wrState_q == W_HAVE_AW && wFire) ||
                    (wrState_q == W_HAVE_W  && awFire);

    always_comb begin
        wrState_d = wrState_q;
        case (wrState_q)
            W_IDLE:    if (awFire && wFire) wrState_d = W_RESP;
                       else if (awFire)     wrState_d = W_HAVE_AW;
                       else if (wFire)      wrState_d = W_HAVE_W;
            W_HAVE_AW: if (wFire)           wrState_d = W_RESP;
            W_HAVE_W:  if (awFire)          wrState_d = W_RESP;
            W_RESP:    if (S_AXI_BREADY)    wrState_d = W_IDLE;
            default:                        wrState_d = W_IDLE;
        endcase
        rdState_d = rdState_q;
        case (rdState_q)
            R_IDLE:  if (arFire)       rdState_d = R_RESP;
            R_RESP:  if (S_AXI_RREADY) rdState_d = R_IDLE;
            default:                   rdState_d = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (wrState_q)
            W_IDLE: begin
                S_AXI_AWREADY = alive_q;
                S_AXI_WREADY  = alive_q;
            end
            W_HAVE_AW: S_AXI_WREADY  = 1'b1;
            W_HAVE_W:  S_AXI_AWREADY = 1'b1;
            W_RESP:    S_AXI_BVALID  = 1'b1;
            default: ;
        endcase
        S_AXI_ARREADY = (rdState_q == R_IDLE) && alive_q;
        S_AXI_RVALID  = (rdState_q == R_RESP);
    end

    // Whichever half arrived first was latched; the other half comes straight from the bus.
    assign wrIdx = (wrState_q == W_HAVE_AW) ? awIdx_q : S_AXI_AWADDR[AW-1:ADDR_LSB];
    assign cData = (wrState_q == W_HAVE_W)  ? wData_q : S_AXI_WDATA;
    assign cStrb = (wrState_q == W_HAVE_W)  ? wStrb_q : S_AXI_WSTRB;
    assign rdIdx = S_AXI_ARADDR[AW-1:ADDR_LSB];

    always_comb begin
        wrSel  = '0;
        rdSel  = '0;
        rdWord = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wrSel[i] = (32'(wrIdx) == i);
            rdSel[i] = (32'(rdIdx) == i);
            if (rdSel[i]) rdWord = RO_MASK[i] ? reg_in[i*DW +: DW] : regVal[i*DW +: DW];
        end
    end

    assign wrOk  = |(wrSel & ~RO_MASK);
    assign rdHit = |rdSel;
    assign wrWe  = (commit && wrOk) ? wrSel : '0;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            awIdx_q   <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bResp_q   <= RESP_OKAY;
            rResp_q   <= RESP_OKAY;
            rData_q   <= '0;
            wrPulse_q <= '0;
            rdPulse_q <= '0;
        end else begin
            if (wrState_q == W_IDLE && awFire) awIdx_q <= S_AXI_AWADDR[AW-1:ADDR_LSB];
            if (wrState_q == W_IDLE && wFire) begin
                wData_q <= S_AXI_WDATA;
                wStrb_q <= S_AXI_WSTRB;
            end
            if (commit) bResp_q <= wrOk ? RESP_OKAY : RESP_SLVERR;
            if (arFire) begin
                rData_q <= rdWord;
                rResp_q <= rdHit ? RESP_OKAY : RESP_SLVERR;
            end
            wrPulse_q <= wrWe;
            rdPulse_q <= (arFire && rdHit) ? rdSel : '0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : gWord
        regbank_word #(
            .DW       (DW),
            .IS_RO    (RO_MASK[i]),
            .IS_PULSE (PULSE_MASK[i]),
            .RST_VAL  (RST_VAL[i*DW +: DW])
        ) uWord (
            .clk_i   (S_AXI_ACLK),
            .rst_i   (S_AXI_ARESET),
            .we_i    (wrWe[i]),
            .wdata_i (cData),
            .wstrb_i (cStrb),
            .q_o     (regVal[i*DW +: DW])
        );
    end

    assign reg_out     = regVal;
    assign wr_pulse    = wrPulse_q;
    assign rd_pulse    = rdPulse_q;
    assign S_AXI_BRESP = bResp_q;
    assign S_AXI_RDATA = rData_q;
    assign S_AXI_RRESP = rResp_q;

endmodule
